// File: rtl/bitscan_encoder_pkg.sv
// Shared types and helpers for the bitscan encoder (package enc_pkg).
// Optional feature macro used by this block: ENC_ZERO_FLAG_EN.
package enc_pkg;

    // Widest request vector the helper functions accept.
    localparam int MAX_N = 64;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        ZERO
    } enc_state_t;

    // Ceiling log2. Used to size index fields from the vector width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r++;
        end
        return r;
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic onehot_count_is_one(input logic [MAX_N-1:0] v);
        return (v != '0) && ((v & (v - MAX_N'(1))) == '0);
    endfunction

endpackage

// File: rtl/bitscan_encoder_if.sv
// Valid/ready bus of the bitscan encoder: request-vector input and index-beat output.
// out_zero exists only when ENC_ZERO_FLAG_EN is defined.
interface bitscan_encoder_if
    import enc_pkg::*;
#(
    parameter int N = 8
) ();

    localparam int W = clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
`ifdef ENC_ZERO_FLAG_EN
    logic         out_zero;
`endif

    // Producer/consumer side that drives vectors and takes beats.
    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_idx,
`ifdef ENC_ZERO_FLAG_EN
        input  out_zero,
`endif
        input  out_last
    );

    // Encoder side.
    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_idx,
`ifdef ENC_ZERO_FLAG_EN
        output out_zero,
`endif
        output out_last
    );

endinterface

// File: rtl/bitscan_encoder_lsb_onehot_enc.sv
// Combinational lowest-set-bit finder: returns the index of the lowest set bit of
// pend and a one-hot mask of that bit (both zero when pend is zero).
module lsb_onehot_enc
    import enc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]          pend,
    output logic [clog2(N)-1:0]   idx,
    output logic [N-1:0]          lsb_mask
);

    localparam int W = clog2(N);

    // Two's-complement trick isolates the lowest set bit.
    assign lsb_mask = pend & (~pend + {{(N-1){1'b0}}, 1'b1});

    // Scan from the top down so the lowest set bit is the last one written.
    // NOTE: idx gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/bitscan_encoder.sv
// Bitscan encoder: takes an N-bit request vector and emits the index of every set
// bit, lowest first, one per beat. A vector taken on the last beat of the previous
// one starts with no idle cycle in between.
// Optional: ENC_ZERO_FLAG_EN makes an all-zero vector produce one beat with out_zero=1;
// without it an all-zero vector is consumed and dropped.
module bitscan_encoder
    import enc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst,
    bitscan_encoder_if.slave  bus
);

    localparam int W = clog2(N);

    enc_state_t   state_q, state_d;
    logic [N-1:0] pend_q, pend_d;

    logic [W-1:0] lsb_idx;
    logic [N-1:0] lsb_mask;
    logic         pend_one;
    logic         out_valid;
    logic         out_last;
    logic         in_ready;
    logic         in_fire;
    logic         out_fire;

    lsb_onehot_enc #(.N(N)) u_lsb (
        .pend     (pend_q),
        .idx      (lsb_idx),
        .lsb_mask (lsb_mask)
    );

    assign pend_one  = onehot_count_is_one(MAX_N'(pend_q));

    // Beat outputs come from state_q/pend_q only, so they hold steady under stall.
    assign out_valid = (state_q != IDLE);
    assign out_last  = (state_q == ZERO) || ((state_q == SCAN) && pend_one);
    assign out_fire  = out_valid && bus.out_ready;
    assign in_ready  = (state_q == IDLE) || (out_fire && out_last);
    assign in_fire   = bus.in_valid && in_ready;

    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_idx   = (state_q == SCAN) ? lsb_idx : '0;
    assign bus.in_ready  = in_ready;
`ifdef ENC_ZERO_FLAG_EN
    assign bus.out_zero  = (state_q == ZERO);
`endif

    // Next state: retire the current beat, then accept a new vector if one is taken.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;

        case (state_q)
            IDLE: begin
            end
            SCAN: begin
                if (out_fire) begin
                    pend_d = pend_q & ~lsb_mask;
                    if (out_last) begin
                        state_d = IDLE;
                    end
                end
            end
`ifdef ENC_ZERO_FLAG_EN
            ZERO: begin
                if (out_fire) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // in_fire is only possible in IDLE or on a last beat, so it overrides the above.
        if (in_fire) begin
            if (bus.in_vec != '0) begin
                state_d = SCAN;
                pend_d  = bus.in_vec;
            end
`ifdef ENC_ZERO_FLAG_EN
            else begin
                state_d = ZERO;
            end
`endif
        end
    end

    // State and pending-bit registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

endmodule
